race_progress_tracker: RTL and testbench

- Consumer end of the distance interface: takes the per-frame accumulated `distance_drove` and `track_length` and turns them into race state.
- Outputs a progress-bar pixel length for the HUD, near-finish and finished flags, and a one-cycle finish pulse to the game controller.
- Progress is computed once per frame with a multi-cycle shift-subtract divider. This avoids a combinational divider in the VGA clock domain.

---
 rtl/race_progress_tracker_pkg.sv | 23 ++
 rtl/race_progress_tracker_if.sv | 24 ++
 rtl/race_progress_tracker_seq_divider.sv | 111 +++++++++++
 rtl/race_progress_tracker.sv | 175 +++++++++++++++++
 tb/tb_race_progress_tracker.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/race_progress_tracker_pkg.sv
// Shared race/progress definitions: FSM encodings, divider width and the
// default bar geometry also used by the HUD bar drawer.
package race_pkg;

   localparam int PX_W_DEF      = 9;
   localparam int DIV_W         = 32 + PX_W_DEF;
   localparam int BAR_LEN_DEF   = 320;
   localparam int NEAR_DIST_DEF = 4096;

   typedef enum logic [1:0] {
      R_IDLE,
      R_RACING,
      R_FINISHED
   } race_state_t;

   typedef enum logic [1:0] {
      D_IDLE,
      D_LOAD,
      D_RUN,
      D_DONE
   } div_state_t;

endpackage

// File: rtl/race_progress_tracker_if.sv
// Distance interface: the per-frame distance producer drives it (master),
// the progress tracker consumes it (slave).
interface race_progress_tracker_if;

   logic               startOfFrame;
   logic               race_enable;
   logic signed [31:0] distance_drove;
   logic signed [31:0] track_length;

   modport master (
      output startOfFrame,
      output race_enable,
      output distance_drove,
      output track_length
   );

   modport slave (
      input startOfFrame,
      input race_enable,
      input distance_drove,
      input track_length
   );

endinterface

// File: rtl/race_progress_tracker_seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock.
// start is accepted only in D_IDLE; operands are read during D_LOAD, so the
// caller must hold num_i/den_i stable for the cycle after start.
// abort returns to D_IDLE at the next edge without producing done.
module seq_divider
   import race_pkg::*;
#(
   parameter int NUM_W  = 41,
   parameter int DEN_W  = 32,
   parameter int QUOT_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [NUM_W-1:0]  num_i,
   input  logic [DEN_W-1:0]  den_i,
   output logic              idle_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [QUOT_W-1:0] quot_o
);

   localparam int CNT_W = $clog2(NUM_W + 1);

   div_state_t        state_q;
   logic              busy_q;
   logic              done_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [NUM_W-1:0]  quot_q;
   logic [DEN_W-1:0]  rem_q;
   logic [DEN_W-1:0]  den_q;

   logic [DEN_W:0]    trial_d;
   logic [DEN_W:0]    diff_d;
   logic              fits_d;

   // One restoring step: shift the next numerator bit into the remainder
   // and subtract the denominator when it fits.
   always_comb begin
      trial_d = {rem_q, quot_q[NUM_W-1]};
      diff_d  = trial_d - {1'b0, den_q};
      fits_d  = (trial_d >= {1'b0, den_q});
   end

   // Divider FSM with registered busy/done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= D_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         den_q   <= '0;
      end else if (abort_i) begin
         state_q <= D_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            D_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  state_q <= D_LOAD;
                  busy_q  <= 1'b1;
               end
            end
            D_LOAD: begin
               quot_q  <= num_i;
               rem_q   <= '0;
               den_q   <= den_i;
               cnt_q   <= CNT_W'(NUM_W);
               state_q <= D_RUN;
            end
            D_RUN: begin
               // Remainder stays below the denominator, so the low DEN_W bits hold it.
               if (fits_d) begin
                  rem_q  <= diff_d[DEN_W-1:0];
                  quot_q <= {quot_q[NUM_W-2:0], 1'b1};
               end else begin
                  rem_q  <= trial_d[DEN_W-1:0];
                  quot_q <= {quot_q[NUM_W-2:0], 1'b0};
               end
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= D_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            D_DONE: begin
               done_q  <= 1'b0;
               state_q <= D_IDLE;
            end
            default: begin
               state_q <= D_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign idle_o = (state_q == D_IDLE);
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign quot_o = quot_q[QUOT_W-1:0];

endmodule

// File: rtl/race_progress_tracker.sv
// race_progress_tracker: turns per-frame distance/track length into race
// state, a HUD progress-bar length and finish flags/pulses.
// Optional checkpoint outputs are built when RACE_PROGRESS_CHECKPOINT_EN is
// defined; the default build omits them.
module race_progress_tracker
   import race_pkg::*;
#(
   parameter int BAR_LEN     = BAR_LEN_DEF,
   parameter int PX_W        = PX_W_DEF,
   parameter int NEAR_DIST   = NEAR_DIST_DEF,
   parameter int CHECKPOINTS = 4
) (
   input  logic                   clk,
   input  logic                   resetN,
   race_progress_tracker_if.slave dif,
   output logic [PX_W-1:0]        progress_px,
   output logic                   progress_valid,
   output logic                   near_finish,
   output logic                   race_finished,
   output logic                   finish_pulse,
   output logic                   busy
`ifdef RACE_PROGRESS_CHECKPOINT_EN
   ,
   output logic                            checkpoint_pulse,
   output logic [$clog2(CHECKPOINTS)-1:0] checkpoint_idx
`endif
);

   localparam int                NUM_W  = 32 + PX_W;
   localparam logic [NUM_W-1:0]  BAR_NW = NUM_W'(BAR_LEN);
   localparam logic [PX_W-1:0]   BAR_PX = PX_W'(BAR_LEN);
   localparam logic [31:0]       NEAR_W = 32'(NEAR_DIST);

   race_state_t       state_q;
   logic [31:0]       d_q;
   logic [31:0]       l_q;
   logic [PX_W-1:0]   px_q;
   logic              valid_q;
   logic              near_q;
   logic              fin_q;
   logic              fp_q;

   logic [31:0]       l_clamp;
   logic [31:0]       d_pos;
   logic [31:0]       d_clamp;
   logic              finish_cond;
   logic              near_cond;
   logic              sample;
   logic              div_start;
   logic              div_idle;
   logic              div_busy;
   logic              div_done;
   logic [PX_W-1:0]   div_quot;
   logic [NUM_W-1:0]  num;

   // Clamp the incoming sample and evaluate finish/near-finish on it.
   always_comb begin
      l_clamp     = (dif.track_length < 0) ? 32'd0 : $unsigned(dif.track_length);
      d_pos       = (dif.distance_drove < 0) ? 32'd0 : $unsigned(dif.distance_drove);
      d_clamp     = (d_pos > l_clamp) ? l_clamp : d_pos;
      finish_cond = (l_clamp == 32'd0) || (d_clamp >= l_clamp);
      near_cond   = ((l_clamp - d_clamp) <= NEAR_W);
      // A frame strobe arriving while the divider is occupied is dropped.
      sample      = dif.startOfFrame && dif.race_enable &&
                    (state_q != R_FINISHED) && div_idle;
      div_start   = sample && !finish_cond;
      num         = {{PX_W{1'b0}}, d_q} * BAR_NW;
   end

   seq_divider #(
      .NUM_W  (NUM_W),
      .DEN_W  (32),
      .QUOT_W (PX_W)
   ) u_div (
      .clk     (clk),
      .rst_n   (resetN),
      .start_i (div_start),
      .abort_i (!dif.race_enable),
      .num_i   (num),
      .den_i   (l_q),
      .idle_o  (div_idle),
      .busy_o  (div_busy),
      .done_o  (div_done),
      .quot_o  (div_quot)
   );

   // Race FSM with registered progress/flag outputs; race_enable low wins.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= R_IDLE;
         d_q     <= '0;
         l_q     <= '0;
         px_q    <= '0;
         valid_q <= 1'b0;
         near_q  <= 1'b0;
         fin_q   <= 1'b0;
         fp_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         fp_q    <= 1'b0;
         if (!dif.race_enable) begin
            state_q <= R_IDLE;
            px_q    <= '0;
            near_q  <= 1'b0;
            fin_q   <= 1'b0;
         end else begin
            if (div_done) begin
               px_q    <= div_quot;
               valid_q <= 1'b1;
            end
            if (sample) begin
               d_q <= d_clamp;
               l_q <= l_clamp;
               if (finish_cond) begin
                  state_q <= R_FINISHED;
                  fp_q    <= 1'b1;
                  fin_q   <= 1'b1;
                  near_q  <= 1'b1;
                  px_q    <= BAR_PX;
               end else begin
                  state_q <= R_RACING;
                  near_q  <= near_cond;
               end
            end
         end
      end
   end

   assign progress_px    = px_q;
   assign progress_valid = valid_q;
   assign near_finish    = near_q;
   assign race_finished  = fin_q;
   assign finish_pulse   = fp_q;
   assign busy           = div_busy;

`ifdef RACE_PROGRESS_CHECKPOINT_EN
   localparam int IDX_W = $clog2(CHECKPOINTS);
   localparam int SEG   = BAR_LEN / CHECKPOINTS;

   logic             cp_hit;
   logic [IDX_W-1:0] cp_k;
   logic             cp_pulse_q;
   logic [IDX_W-1:0] cp_idx_q;

   // Highest segment boundary crossed upward by the new divider result.
   always_comb begin
      cp_hit = 1'b0;
      cp_k   = '0;
      for (int k = 1; k < CHECKPOINTS; k++) begin
         if ((int'(px_q) < k * SEG) && (int'(div_quot) >= k * SEG)) begin
            cp_hit = 1'b1;
            cp_k   = IDX_W'(k);
         end
      end
   end

   // Checkpoint pulse/index registers; index holds between pulses.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cp_pulse_q <= 1'b0;
         cp_idx_q   <= '0;
      end else begin
         cp_pulse_q <= 1'b0;
         if (dif.race_enable && div_done && cp_hit) begin
            cp_pulse_q <= 1'b1;
            cp_idx_q   <= cp_k;
         end
      end
   end

   assign checkpoint_pulse = cp_pulse_q;
   assign checkpoint_idx   = cp_idx_q;
`endif

endmodule

// File: tb/tb_race_progress_tracker.sv
// Bench for race_progress_tracker: directed frames with literal expectations
// plus a cycle-level reference model compared on every falling clock edge.
module tb_race_progress_tracker;

   localparam int BAR  = 320;
   localparam int NEAR = 4096;

   logic       clk;
   logic       resetN;
   logic [8:0] progress_px;
   logic       progress_valid;
   logic       near_finish;
   logic       race_finished;
   logic       finish_pulse;
   logic       busy;
`ifdef RACE_PROGRESS_CHECKPOINT_EN
   logic       checkpoint_pulse;
   logic [1:0] checkpoint_idx;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   race_progress_tracker_if dif ();

   race_progress_tracker dut (
      .clk            (clk),
      .resetN         (resetN),
      .dif            (dif.slave),
      .progress_px    (progress_px),
      .progress_valid (progress_valid),
      .near_finish    (near_finish),
      .race_finished  (race_finished),
      .finish_pulse   (finish_pulse),
      .busy           (busy)
`ifdef RACE_PROGRESS_CHECKPOINT_EN
      ,
      .checkpoint_pulse (checkpoint_pulse),
      .checkpoint_idx   (checkpoint_idx)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(string nm, longint act, longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference model: race rules in plain arithmetic; the divider is a
   // delayed exact integer quotient.
   int     m_state;   // 0 idle, 1 racing, 2 finished
   int     m_rcnt;    // edges until result appears
   int     m_bcnt;    // remaining busy cycles
   longint m_res;
   longint m_L, m_D;
   bit     m_can;
   int     e_px;
   bit     e_pv, e_near, e_fin, e_fp;

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         m_state = 0; m_rcnt = 0; m_bcnt = 0; m_res = 0;
         e_px = 0; e_pv = 0; e_near = 0; e_fin = 0; e_fp = 0;
      end else begin
         m_can = (m_rcnt == 0);
         e_pv  = 0;
         e_fp  = 0;
         if (!dif.race_enable) begin
            m_state = 0; m_rcnt = 0; m_bcnt = 0;
            e_px = 0; e_near = 0; e_fin = 0;
         end else begin
            if (m_bcnt > 0) m_bcnt--;
            if (m_rcnt > 0) begin
               m_rcnt--;
               if (m_rcnt == 0) begin
                  e_px = int'(m_res);
                  e_pv = 1;
               end
            end
            if (dif.startOfFrame && m_state != 2 && m_can) begin
               m_L = (dif.track_length < 0) ? 0 : longint'(dif.track_length);
               m_D = (dif.distance_drove < 0) ? 0 : longint'(dif.distance_drove);
               if (m_D > m_L) m_D = m_L;
               if (m_L == 0 || m_D >= m_L) begin
                  m_state = 2; e_fin = 1; e_near = 1; e_fp = 1; e_px = BAR;
               end else begin
                  m_state = 1;
                  e_near  = ((m_L - m_D) <= NEAR);
                  m_res   = (m_D * BAR) / m_L;
                  m_rcnt  = 43;
                  m_bcnt  = 42;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("model_progress_px", progress_px, e_px);
      chk("model_progress_valid", progress_valid, e_pv);
      chk("model_near_finish", near_finish, e_near);
      chk("model_race_finished", race_finished, e_fin);
      chk("model_finish_pulse", finish_pulse, e_fp);
      chk("model_busy", busy, (m_bcnt > 0));
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frame(int d);
      dif.distance_drove = d;
      dif.startOfFrame   = 1'b1;
      tick();
      dif.startOfFrame   = 1'b0;
   endtask

   // Called right after frame(); returns clocks from the sampling edge to
   // progress_valid (0 if it never came) and the number of busy cycles.
   task automatic wait_valid(output int lat, output int bc);
      lat = 0;
      bc  = busy ? 1 : 0;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (progress_valid) begin
            lat = i;
            break;
         end
         if (busy) bc++;
      end
   endtask

   int lat, bc, cnt, cnt2, px_seen;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetN = 1'b0;
      dif.startOfFrame   = 1'b0;
      dif.race_enable    = 1'b0;
      dif.distance_drove = 0;
      dif.track_length   = 0;
      tick(3);
      chk("reset_px", progress_px, 0);
      chk("reset_flags", {progress_valid, near_finish, race_finished, finish_pulse, busy}, 0);
      resetN = 1'b1;
      tick(2);

      // Half distance: 160 px, 43-clock latency, 42 busy clocks.
      dif.race_enable  = 1'b1;
      dif.track_length = 51200;
      tick();
      frame(25600);
      wait_valid(lat, bc);
      chk("half_latency", lat, 43);
      chk("half_px", progress_px, 160);
      chk("half_busy_cycles", bc, 42);
      chk("half_near", near_finish, 0);
      tick();
      chk("half_valid_one_cycle", progress_valid, 0);

      // Near finish then crossing the line.
      frame(48000);
      wait_valid(lat, bc);
      chk("near_px", progress_px, 300);
      chk("near_flag", near_finish, 1);
      tick(2);
      frame(51200);
      chk("finish_pulse_hi", finish_pulse, 1);
      chk("finish_flag", race_finished, 1);
      chk("finish_px", progress_px, 320);
      tick();
      chk("finish_pulse_lo", finish_pulse, 0);
      cnt = 0;
      for (int f = 0; f < 2; f++) begin
         frame(60000);
         if (finish_pulse) cnt++;
         for (int i = 0; i < 5; i++) begin
            tick();
            if (finish_pulse) cnt++;
         end
      end
      chk("finished_no_repulse", cnt, 0);
      chk("finished_sticky", race_finished, 1);
      chk("finished_near", near_finish, 1);

      // Race disabled returns to idle.
      dif.race_enable = 1'b0;
      tick(2);
      chk("idle_px", progress_px, 0);
      chk("idle_flags", {near_finish, race_finished}, 0);

      // Zero and negative track length finish at once, divider never busy.
      for (int t = 0; t < 2; t++) begin
         dif.track_length = (t == 0) ? 0 : -5;
         dif.race_enable  = 1'b1;
         tick();
         frame((t == 0) ? 1000 : 5);
         chk("zero_len_finished", race_finished, 1);
         chk("zero_len_px", progress_px, 320);
         cnt = 0;
         for (int i = 0; i < 50; i++) begin
            if (busy) cnt++;
            tick();
         end
         chk("zero_len_never_busy", cnt, 0);
         dif.race_enable = 1'b0;
         tick(2);
      end

      // Negative distance clamps to zero progress.
      dif.track_length = 51200;
      dif.race_enable  = 1'b1;
      tick();
      frame(-100);
      wait_valid(lat, bc);
      chk("neg_dist_latency", lat, 43);
      chk("neg_dist_px", progress_px, 0);
      tick(2);

      // Second frame strobe while busy is dropped.
      frame(12800);
      tick(9);
      frame(40000);
      cnt = 0;
      px_seen = -1;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (progress_valid) begin
            cnt++;
            px_seen = int'(progress_px);
         end
      end
      chk("busy_drop_valid_count", cnt, 1);
      chk("busy_drop_px", px_seen, 80);

      // race_enable dropped mid-division.
      frame(25600);
      tick(19);
      dif.race_enable = 1'b0;
      cnt = 0;
      cnt2 = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (progress_valid) cnt++;
         if (busy) cnt2++;
      end
      chk("abort_no_valid", cnt, 0);
      chk("abort_no_busy", cnt2, 0);
      chk("abort_px", progress_px, 0);
      chk("abort_flags", {near_finish, race_finished, finish_pulse}, 0);

      // Reset pulsed mid-division.
      dif.race_enable = 1'b1;
      tick();
      frame(48000);
      tick(19);
      resetN = 1'b0;
      tick(2);
      chk("rst_mid_busy", busy, 0);
      resetN = 1'b1;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (progress_valid || finish_pulse) cnt++;
      end
      chk("rst_mid_no_pulse", cnt, 0);
      chk("rst_mid_px", progress_px, 0);
      chk("rst_mid_flags", {near_finish, race_finished}, 0);

`ifdef RACE_PROGRESS_CHECKPOINT_EN
      // Checkpoint crossing 62 -> 187 passes boundaries 80 and 160.
      dif.race_enable = 1'b0;
      tick(2);
      dif.race_enable = 1'b1;
      tick();
      frame(10000);
      wait_valid(lat, bc);
      chk("cp_first_px", progress_px, 62);
      tick(2);
      frame(30000);
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (checkpoint_pulse) cnt++;
      end
      chk("cp_second_px", progress_px, 187);
      chk("cp_pulse_count", cnt, 1);
      chk("cp_idx", checkpoint_idx, 2);
`endif

      tick(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
